mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  MEM stage plus MEM/WB pipeline register; consumes the EX/MEM register outputs.
//  Drives a req/ack data-memory bus with byte/half/word access, sign/zero load
//  extension and misalignment/timeout fault detection.
//  Raises stall_mem to freeze upstream stages while an access is outstanding.
//  Registers the writeback result, destination and Tnew for the WB stage and the
//  forwarding logic.
// PARAMETERS
//  TIMEOUT  16  cycles in WAIT without dm_ack before the access is abandoned (>=2)
// PORTS
//  clk           in   1   rising-edge clock
//  reset         in   1   asynchronous, active-low
//  regwriteM     in   1   instruction writes the register file
//  memtoregM     in   1   load: result comes from memory
//  memwriteM     in   1   store
//  mem_sizeM     in   2   00 byte, 01 half, 10 word (11 treated as word)
//  mem_unsignedM in   1   1 = zero-extend loads, 0 = sign-extend
//  alu_outM      in   32  effective address / ALU result
//  write_dataM   in   32  store data (rt value)
//  write_regM    in   5   destination register
//  Tnew_M        in   2   cycles until the result is available
//  dm_req        out  1   memory request valid
//  dm_we         out  1   1 = write
//  dm_addr       out  32  word-aligned address ({addr[31:2],2'b00})
//  dm_be         out  4   byte enables, bit i = byte lane i (little-endian)
//  dm_wdata      out  32  store data, replicated into every lane
//  dm_ack        in   1   request accepted/completed this cycle
//  dm_rdata      in   32  read data; valid when dm_ack=1
//  stall_mem     out  1   hold PC/IF/ID/EX/EX-MEM registers this cycle
//  mem_fault     out  1   one-cycle pulse: misaligned access or timeout
//  regwriteW     out  1   writeback enable
//  write_regW    out  5   writeback destination
//  resultW       out  32  writeback data
//  Tnew_W        out  2   Tnew for the WB stage
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, timeout counter=0, all registered outputs 0.
//   While in reset, dm_req=0, stall_mem=0 and mem_fault=0.
//  A memory op is memtoregM|memwriteM. Misaligned: half with addr[0]=1, or word
//   with addr[1:0]!=0.
//  FSM IDLE:
//   - No memory op: WB register loads from the inputs every cycle.
//     Latency from MEM to WB is 1 cycle.
//   - Misaligned op: no request is issued. mem_fault=1 for that cycle.
//     WB loads regwriteW=0; no stall.
//   - Aligned op: dm_req=1 combinationally, driven from the inputs.
//     - dm_ack=1 in the same cycle: access completes, no stall.
//     - Otherwise: stall_mem=1, latch addr/data/size/control/dest, go to WAIT.
//       WB loads a bubble (regwriteW=0).
//  FSM WAIT:
//   - dm_req=1, driven from the latched values, which stay stable until ack.
//   - stall_mem = ~dm_ack. The counter increments each cycle without ack.
//   - dm_ack=1: complete from the latched values. Go to IDLE and clear the
//     counter. Upstream resumes on the next edge.
//   - Counter reaches TIMEOUT-1 without ack: mem_fault=1 and dm_req drops.
//     WB loads regwriteW=0. Go to IDLE; stall_mem=0 that cycle.
//   - A late dm_ack seen in IDLE with no request is ignored.
//  Completion (loads and stores) updates the WB register in the same cycle:
//   - regwriteW = regwrite; write_regW = dest.
//   - resultW = memtoreg ? ext(lane) : alu_out.
//   - Tnew_W = (Tnew>0) ? Tnew-1 : 0 (saturating).
//  Load lanes:
//   - byte: addr[1:0] selects dm_rdata[8*a+7:8*a].
//   - half: addr[1] selects the low or high 16 bits.
//   - Extend per mem_unsigned.
//  Store enables:
//   - byte: be = 1<<addr[1:0], wdata = {4{data[7:0]}}.
//   - half: be = addr[1] ? 1100 : 0011, wdata = {2{data[15:0]}}.
//   - word: be = 1111.
//  Loads drive dm_we=0 and dm_be=1111.
//  A store completes with regwriteW as supplied (normally 0).
//  While stall_mem=1, the inputs may change (upstream is frozen, but that is not
//   relied on); only the latched copies are used.
//  Asserting reset mid-WAIT aborts the access immediately.
// TESTING
//  1. ALU op with alu_out=0x1234, regwrite=1, rd=5, Tnew=1 -> next cycle
//     resultW=0x1234, write_regW=5, Tnew_W=0, no dm_req.
//  2. Load byte signed at addr 0x1003, dm_ack same cycle with rdata=0x80FFFFFF
//     -> resultW=0xFFFFFF80, stall_mem never 1.
//  3. Store half at 0x2002 with data 0xABCD1234, ack after 3 cycles ->
//     stall_mem=1 for exactly 3 cycles; dm_be=1100, dm_wdata=0x12341234,
//     dm_addr=0x2000 stable throughout.
//  4. Load word at 0x4001 -> no dm_req, mem_fault pulse of 1 cycle,
//     regwriteW=0.
//  5. Load with no ack for TIMEOUT=16 cycles -> mem_fault at cycle 16,
//     stall drops, regwriteW=0; a late ack afterwards has no effect.
//  6. Reset pulled low while in WAIT -> all outputs 0 asynchronously; after
//     release, IDLE and a fresh load of 0x55 with ack completes normally.

Source files
------------

// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
//   MEM stage plus MEM/WB pipeline register. Takes the EX/MEM register
//   outputs and drives a req/ack data-memory bus with byte/half/word access.
//   Load data is sign- or zero-extended. Misaligned accesses and bus
//   timeouts produce a one-cycle fault pulse. While an access is
//   outstanding, stall_mem freezes the upstream stages. The writeback
//   result, destination and Tnew are registered for WB and for forwarding.
//
// Parameters
//   TIMEOUT       cycles of unacknowledged request before abandoning (>=2)
//
// Ports
//   clk, reset                  clock, asynchronous active-low reset
//   regwriteM .. Tnew_M         EX/MEM register outputs
//   dm_req/we/addr/be/wdata     data-memory request (outputs)
//   dm_ack, dm_rdata            data-memory response (inputs)
//   stall_mem                   hold upstream pipeline registers
//   mem_fault                   one-cycle misalignment/timeout pulse
//   regwriteW, write_regW,
//   resultW, Tnew_W             MEM/WB register outputs
// ---------------------------------------------------------------------------
module mem_wb_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        regwriteM,
  input  logic        memtoregM,
  input  logic        memwriteM,
  input  logic [1:0]  mem_sizeM,
  input  logic        mem_unsignedM,
  input  logic [31:0] alu_outM,
  input  logic [31:0] write_dataM,
  input  logic [4:0]  write_regM,
  input  logic [1:0]  Tnew_M,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        stall_mem,
  output logic        mem_fault,
  output logic        regwriteW,
  output logic [4:0]  write_regW,
  output logic [31:0] resultW,
  output logic [1:0]  Tnew_W
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  // FSM and timeout counter
  logic [0:0]    r_state;
  logic [CW-1:0] r_cnt;

  // Latched copy of the access, held while waiting for dm_ack
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic        r_memtoreg;
  logic        r_memwrite;
  logic        r_regwrite;
  logic [4:0]  r_dest;
  logic [1:0]  r_tnew;

  // MEM/WB register
  logic        r_regwriteW;
  logic [4:0]  r_write_regW;
  logic [31:0] r_resultW;
  logic [1:0]  r_Tnew_W;

  // Active access fields: latched copy while waiting, live inputs otherwise
  logic        w_wait;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic [1:0]  w_size;
  logic        w_unsigned;
  logic        w_memtoreg;
  logic        w_memwrite;
  logic        w_regwrite;
  logic [4:0]  w_dest;
  logic [1:0]  w_tnew;

  assign w_wait     = (r_state == ST_WAIT);
  assign w_addr     = w_wait ? r_addr     : alu_outM;
  assign w_data     = w_wait ? r_data     : write_dataM;
  assign w_size     = w_wait ? r_size     : mem_sizeM;
  assign w_unsigned = w_wait ? r_unsigned : mem_unsignedM;
  assign w_memtoreg = w_wait ? r_memtoreg : memtoregM;
  assign w_memwrite = w_wait ? r_memwrite : memwriteM;
  assign w_regwrite = w_wait ? r_regwrite : regwriteM;
  assign w_dest     = w_wait ? r_dest     : write_regM;
  assign w_tnew     = w_wait ? r_tnew     : Tnew_M;

  logic w_memop_in;
  logic w_misaligned_in;
  logic w_timeout;
  logic w_req;
  logic w_complete;
  logic w_pass_alu;

  assign w_memop_in      = memtoregM | memwriteM;
  // Size 11 is treated as word, so size[1] alone marks a word access.
  assign w_misaligned_in = ((mem_sizeM == 2'b01) & alu_outM[0]) |
                           (mem_sizeM[1] & (alu_outM[1:0] != 2'b00));
  assign w_timeout       = w_wait & (r_cnt == CNT_LAST);

  // The request is gated by reset so that nothing leaks onto the bus from
  // the live inputs while reset is held.
  assign w_req      = reset & (w_wait ? ~w_timeout
                                      : (w_memop_in & ~w_misaligned_in));
  assign w_complete = w_req & dm_ack;
  assign w_pass_alu = ~w_wait & ~w_memop_in;

  assign stall_mem = w_req & ~dm_ack;
  assign mem_fault = reset & (w_timeout |
                              (~w_wait & w_memop_in & w_misaligned_in));

  // Store lane steering
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = w_data;
    if (w_memwrite) begin
      case (w_size)
        2'b00: begin
          w_be    = 4'b0001 << w_addr[1:0];
          w_wdata = {4{w_data[7:0]}};
        end
        2'b01: begin
          w_be    = w_addr[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{w_data[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = w_data;
        end
      endcase
    end
  end

  assign dm_req   = w_req;
  assign dm_we    = w_req & w_memwrite;
  assign dm_addr  = w_req ? {w_addr[31:2], 2'b00} : 32'd0;
  assign dm_be    = w_req ? w_be : 4'd0;
  assign dm_wdata = w_req ? w_wdata : 32'd0;

  // Load lane selection and extension
  logic [7:0]  w_lane_b;
  logic [15:0] w_lane_h;
  logic [31:0] w_load_val;

  always_comb begin
    w_lane_b = dm_rdata[7:0];
    case (w_addr[1:0])
      2'b00:   w_lane_b = dm_rdata[7:0];
      2'b01:   w_lane_b = dm_rdata[15:8];
      2'b10:   w_lane_b = dm_rdata[23:16];
      default: w_lane_b = dm_rdata[31:24];
    endcase
  end

  assign w_lane_h = w_addr[1] ? dm_rdata[31:16] : dm_rdata[15:0];

  always_comb begin
    w_load_val = dm_rdata;
    case (w_size)
      2'b00:   w_load_val = w_unsigned ? {24'd0, w_lane_b}
                                       : {{24{w_lane_b[7]}}, w_lane_b};
      2'b01:   w_load_val = w_unsigned ? {16'd0, w_lane_h}
                                       : {{16{w_lane_h[15]}}, w_lane_h};
      default: w_load_val = dm_rdata;
    endcase
  end

  logic [1:0] w_tnew_dec;
  assign w_tnew_dec = (w_tnew != 2'd0) ? (w_tnew - 2'd1) : 2'd0;

  // Next-state logic
  logic [0:0]    w_state_next;
  logic [CW-1:0] w_cnt_next;
  logic          w_latch;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_latch      = 1'b0;
    if (!w_wait) begin
      if (w_req && !dm_ack) begin
        w_state_next = ST_WAIT;
        // The issuing cycle already counts as one unacknowledged cycle.
        w_cnt_next   = CW'(1);
        w_latch      = 1'b1;
      end
    end else begin
      if (w_timeout || dm_ack) begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end else begin
        w_cnt_next   = r_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_addr     <= 32'd0;
      r_data     <= 32'd0;
      r_size     <= 2'd0;
      r_unsigned <= 1'b0;
      r_memtoreg <= 1'b0;
      r_memwrite <= 1'b0;
      r_regwrite <= 1'b0;
      r_dest     <= 5'd0;
      r_tnew     <= 2'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_latch) begin
        r_addr     <= alu_outM;
        r_data     <= write_dataM;
        r_size     <= mem_sizeM;
        r_unsigned <= mem_unsignedM;
        r_memtoreg <= memtoregM;
        r_memwrite <= memwriteM;
        r_regwrite <= regwriteM;
        r_dest     <= write_regM;
        r_tnew     <= Tnew_M;
      end
    end
  end

  // MEM/WB register: completion or pass-through loads a result, every
  // other case (fault, stall) inserts a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_regwriteW  <= 1'b0;
      r_write_regW <= 5'd0;
      r_resultW    <= 32'd0;
      r_Tnew_W     <= 2'd0;
    end else if (w_complete || w_pass_alu) begin
      r_regwriteW  <= w_regwrite;
      r_write_regW <= w_dest;
      r_resultW    <= w_memtoreg ? w_load_val : w_addr;
      r_Tnew_W     <= w_tnew_dec;
    end else begin
      r_regwriteW  <= 1'b0;
      r_write_regW <= 5'd0;
      r_resultW    <= 32'd0;
      r_Tnew_W     <= 2'd0;
    end
  end

  assign regwriteW  = r_regwriteW;
  assign write_regW = r_write_regW;
  assign resultW    = r_resultW;
  assign Tnew_W     = r_Tnew_W;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  logic        clk;
  logic        reset;
  logic        regwriteM, memtoregM, memwriteM, mem_unsignedM;
  logic [1:0]  mem_sizeM, Tnew_M;
  logic [31:0] alu_outM, write_dataM;
  logic [4:0]  write_regM;
  logic        dm_req, dm_we, dm_ack, stall_mem, mem_fault, regwriteW;
  logic [31:0] dm_addr, dm_wdata, dm_rdata, resultW;
  logic [3:0]  dm_be;
  logic [4:0]  write_regW;
  logic [1:0]  Tnew_W;

  mem_wb_stage #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .regwriteM(regwriteM), .memtoregM(memtoregM), .memwriteM(memwriteM),
    .mem_sizeM(mem_sizeM), .mem_unsignedM(mem_unsignedM),
    .alu_outM(alu_outM), .write_dataM(write_dataM),
    .write_regM(write_regM), .Tnew_M(Tnew_M),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .stall_mem(stall_mem), .mem_fault(mem_fault),
    .regwriteW(regwriteW), .write_regW(write_regW),
    .resultW(resultW), .Tnew_W(Tnew_W)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        full;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] res;
    logic [1:0]  tn;
  } exp_t;

  exp_t sb_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   stall_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rw, input logic mtr, input logic mw,
                       input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [4:0] rd, input logic [1:0] tn,
                       input logic ack, input logic [31:0] rdata);
    regwriteM = rw; memtoregM = mtr; memwriteM = mw; mem_sizeM = sz;
    mem_unsignedM = uns; alu_outM = addr; write_dataM = data;
    write_regM = rd; Tnew_M = tn; dm_ack = ack; dm_rdata = rdata;
  endtask

  task automatic set_idle();
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0, 5'd0, 2'd0, 1'b0, 32'd0);
  endtask

  task automatic push_full(input logic rw, input logic [4:0] rd,
                           input logic [31:0] res, input logic [1:0] tn);
    exp_t e;
    e.full = 1'b1; e.rw = rw; e.rd = rd; e.res = res; e.tn = tn;
    sb_q.push_back(e);
  endtask

  task automatic push_bubble();
    exp_t e;
    e = '0;
    sb_q.push_back(e);
  endtask

  // Advance one clock and compare the WB register against the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_empty: observed no expected entry, expected one queued");
    end else begin
      e = sb_q.pop_front();
      chk("wb_regwrite", {31'd0, regwriteW}, {31'd0, e.rw});
      if (e.full) begin
        chk("wb_write_reg", {27'd0, write_regW}, {27'd0, e.rd});
        chk("wb_result", resultW, e.res);
        chk("wb_tnew", {30'd0, Tnew_W}, {30'd0, e.tn});
      end
      $display("[%0t] WB rw=%0b rd=%0d result=%h tnew=%0d", $time,
               regwriteW, write_regW, resultW, Tnew_W);
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    set_idle();
    alu_outM = 32'h0000_4001;     // misaligned word address on live inputs
    memtoregM = 1'b1;
    mem_sizeM = 2'b10;
    #1;
    chk("rst_dm_req", {31'd0, dm_req}, 32'd0);
    chk("rst_stall", {31'd0, stall_mem}, 32'd0);
    chk("rst_fault", {31'd0, mem_fault}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_regwriteW", {31'd0, regwriteW}, 32'd0);
    chk("rst_resultW", resultW, 32'd0);
    chk("rst_write_regW", {27'd0, write_regW}, 32'd0);
    chk("rst_tnewW", {30'd0, Tnew_W}, 32'd0);
    @(negedge clk);
    set_idle();
    reset = 1'b1;

    // 1: ALU pass-through
    drive(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_1234, 32'd0, 5'd5, 2'd1, 1'b0, 32'd0);
    #1 chk("t1_no_req", {31'd0, dm_req}, 32'd0);
    push_full(1'b1, 5'd5, 32'h0000_1234, 2'd0);
    tick();

    // 2: signed byte load, ack same cycle
    drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'd0, 5'd7, 2'd2, 1'b1, 32'h80FF_FFFF);
    #1;
    chk("t2_req", {31'd0, dm_req}, 32'd1);
    chk("t2_stall", {31'd0, stall_mem}, 32'd0);
    chk("t2_we", {31'd0, dm_we}, 32'd0);
    chk("t2_be", {28'd0, dm_be}, 32'hF);
    chk("t2_addr", dm_addr, 32'h0000_1000);
    push_full(1'b1, 5'd7, 32'hFFFF_FF80, 2'd1);
    tick();

    // Extra lane/extension patterns, all acked in the issuing cycle
    drive(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_3002, 32'd0, 5'd8, 2'd0, 1'b1, 32'hBEEF_1234);
    #1 chk("hu_stall", {31'd0, stall_mem}, 32'd0);
    push_full(1'b1, 5'd8, 32'h0000_BEEF, 2'd0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_3001, 32'd0, 5'd10, 2'd3, 1'b1, 32'h0000_AB00);
    push_full(1'b1, 5'd10, 32'h0000_00AB, 2'd2);
    tick();
    drive(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_3000, 32'd0, 5'd11, 2'd1, 1'b1, 32'h0000_8001);
    push_full(1'b1, 5'd11, 32'hFFFF_8001, 2'd0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_3003, 32'h0000_00C3, 5'd0, 2'd0, 1'b1, 32'd0);
    #1;
    chk("sb_be", {28'd0, dm_be}, 32'h8);
    chk("sb_wdata", dm_wdata, 32'hC3C3_C3C3);
    chk("sb_we", {31'd0, dm_we}, 32'd1);
    push_full(1'b0, 5'd0, 32'h0000_3003, 2'd0);
    tick();

    // 3: half store, ack on the fourth request cycle; inputs scrambled
    stall_cnt = 0;
    drive(1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'hABCD_1234, 5'd9, 2'd2, 1'b0, 32'd0);
    for (int c = 0; c < 4; c++) begin
      if (c > 0)
        drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'hDEAD_0001, 32'h5555_AAAA, 5'd31, 2'd3, (c == 3), 32'hFFFF_FFFF);
      #1;
      if (stall_mem === 1'b1) stall_cnt++;
      chk("t3_req", {31'd0, dm_req}, 32'd1);
      chk("t3_we", {31'd0, dm_we}, 32'd1);
      chk("t3_addr", dm_addr, 32'h0000_2000);
      chk("t3_be", {28'd0, dm_be}, 32'hC);
      chk("t3_wdata", dm_wdata, 32'h1234_1234);
      if (c == 3) push_full(1'b0, 5'd9, 32'h0000_2002, 2'd1);
      else        push_bubble();
      tick();
    end
    chk("t3_stall_cycles", stall_cnt, 32'd3);
    set_idle();
    #1 chk("t3_back_idle", {31'd0, dm_req}, 32'd0);
    push_full(1'b0, 5'd0, 32'd0, 2'd0);
    tick();

    // 4: misaligned word load
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_4001, 32'd0, 5'd4, 2'd1, 1'b0, 32'd0);
    #1;
    chk("t4_no_req", {31'd0, dm_req}, 32'd0);
    chk("t4_fault", {31'd0, mem_fault}, 32'd1);
    chk("t4_stall", {31'd0, stall_mem}, 32'd0);
    push_bubble();
    tick();
    set_idle();
    #1 chk("t4_fault_pulse", {31'd0, mem_fault}, 32'd0);
    push_full(1'b0, 5'd0, 32'd0, 2'd0);
    tick();

    // 5: timeout after 16 cycles, then a late ack
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_5000, 32'd0, 5'd6, 2'd1, 1'b0, 32'd0);
    for (int k = 1; k <= 16; k++) begin
      #1;
      chk($sformatf("t5_req_c%0d", k), {31'd0, dm_req}, {31'd0, (k < 16)});
      chk($sformatf("t5_stall_c%0d", k), {31'd0, stall_mem}, {31'd0, (k < 16)});
      chk($sformatf("t5_fault_c%0d", k), {31'd0, mem_fault}, {31'd0, (k == 16)});
      push_bubble();
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_0077, 32'd0, 5'd2, 2'd0, 1'b1, 32'h1111_1111);
    #1;
    chk("t5_late_req", {31'd0, dm_req}, 32'd0);
    chk("t5_late_fault", {31'd0, mem_fault}, 32'd0);
    chk("t5_late_stall", {31'd0, stall_mem}, 32'd0);
    push_full(1'b0, 5'd2, 32'h0000_0077, 2'd0);
    tick();

    // 6: reset asserted mid-WAIT
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_6000, 32'd0, 5'd12, 2'd1, 1'b0, 32'd0);
    push_bubble();
    tick();
    #1;
    chk("t6_wait_req", {31'd0, dm_req}, 32'd1);
    chk("t6_wait_stall", {31'd0, stall_mem}, 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("t6_rst_req", {31'd0, dm_req}, 32'd0);
    chk("t6_rst_stall", {31'd0, stall_mem}, 32'd0);
    chk("t6_rst_fault", {31'd0, mem_fault}, 32'd0);
    chk("t6_rst_addr", dm_addr, 32'd0);
    chk("t6_rst_regwriteW", {31'd0, regwriteW}, 32'd0);
    chk("t6_rst_resultW", resultW, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    set_idle();
    reset = 1'b1;
    #1;
    chk("t6_idle_req", {31'd0, dm_req}, 32'd0);
    chk("t6_idle_stall", {31'd0, stall_mem}, 32'd0);
    push_full(1'b0, 5'd0, 32'd0, 2'd0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_7000, 32'd0, 5'd3, 2'd2, 1'b1, 32'h0000_0055);
    #1;
    chk("t6_load_req", {31'd0, dm_req}, 32'd1);
    chk("t6_load_stall", {31'd0, stall_mem}, 32'd0);
    push_full(1'b1, 5'd3, 32'h0000_0055, 2'd1);
    tick();
    set_idle();

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
